// File: rtl/bit_stream_serializer_pkg.sv
// Shared definitions for the bit-stream serializer: state encoding and counter sizing.
package bit_stream_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_stream_serializer_bit_period_timer.sv
// Down-counter with load, automatic reload on terminal count, and a terminal-count strobe.
module bit_period_timer
    import bit_stream_serializer_pkg::*;
#(
    parameter int MAX_VAL = 1,
    parameter int CW      = cnt_width(MAX_VAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [CW-1:0] i_reload,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_reload;
        end else if (i_en) begin
            r_count <= (r_count == '0) ? i_reload : r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial stage: accepts a word over valid/ready and emits it one bit per bit period.
module bit_stream_serializer
    import bit_stream_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   BIT_CYCLES = 1,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_BITS   = 0,
    parameter logic IDLE_BIT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW      = $clog2(WIDTH) + 1;
    localparam int CYC_MAX = BIT_CYCLES - 1;
    localparam int GAP_CYC = GAP_BITS * BIT_CYCLES;
    localparam int GAP_MAX = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam int CW      = cnt_width(CYC_MAX);
    localparam int GW      = cnt_width(GAP_MAX);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_done;

    logic [CW-1:0]    w_cyc_cnt;
    logic             w_cyc_tc;
    logic [GW-1:0]    w_unused_gap_cnt;
    logic             w_gap_tc;
    logic             w_end;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_done_next;
    logic [WIDTH-1:0] w_shifted;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign w_shifted    = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);
    assign w_end        = (r_state == ST_SHIFT) && (r_bit_cnt == '0) && w_cyc_tc;
    assign w_load_ready = (r_state == ST_IDLE) || (w_end && (GAP_BITS == 0));
    assign w_accept     = load_valid && w_load_ready;

    bit_period_timer #(.MAX_VAL(CYC_MAX), .CW(CW)) u_cyc_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_en     (r_state == ST_SHIFT),
        .i_reload (CW'(CYC_MAX)),
        .o_count  (w_cyc_cnt),
        .o_tc     (w_cyc_tc)
    );

    bit_period_timer #(.MAX_VAL(GAP_MAX), .CW(GW)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_end && !w_accept),
        .i_en     (r_state == ST_GAP),
        .i_reload (GW'(GAP_MAX)),
        .o_count  (w_unused_gap_cnt),
        .o_tc     (w_gap_tc)
    );

    // done is registered, so it is raised one edge ahead: when the next cycle is the word's last.
    always_comb begin
        w_done_next = 1'b0;
        if (w_accept) begin
            w_done_next = (WIDTH == 1) && (BIT_CYCLES == 1);
        end else if ((r_state == ST_SHIFT) && !w_end) begin
            w_done_next = ((r_bit_cnt == '0) && (w_cyc_cnt == CW'(1))) ||
                          ((r_bit_cnt == BW'(1)) && w_cyc_tc && (BIT_CYCLES == 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_ser_out   <= IDLE_BIT;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_accept) begin
                r_state     <= ST_SHIFT;
                r_shreg     <= load_data;
                r_bit_cnt   <= BW'(WIDTH - 1);
                r_ser_out   <= head(load_data);
                r_ser_valid <= 1'b1;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (w_end) begin
                            r_state     <= (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
                            r_ser_out   <= IDLE_BIT;
                            r_ser_valid <= 1'b0;
                        end else if (w_cyc_tc) begin
                            r_shreg   <= w_shifted;
                            r_bit_cnt <= r_bit_cnt - BW'(1);
                            r_ser_out <= head(w_shifted);
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_tc) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign load_ready = w_load_ready;
    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign done       = r_done;
    assign busy       = (r_state != ST_IDLE);

endmodule
